// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/debug memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    typedef enum logic {
        GNT_CPU,
        GNT_DBG
    } grant_t;

    localparam int unsigned LAT_CNT_W = 3;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant decision between CPU and debug requesters.
// MEM_ARB_FIXED_PRIO_EN: when defined, the CPU wins every contention; otherwise round-robin.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dbg_req,
    input  grant_t last_grant,
    output logic   any_req,
    output grant_t grant
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;
`endif

    always_comb begin
        any_req = cpu_req | dbg_req;
        grant   = GNT_CPU;
        if (cpu_req && dbg_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            grant = GNT_CPU;
`else
            grant = (last_grant == GNT_CPU) ? GNT_DBG : GNT_CPU;
`endif
        end else if (dbg_req) begin
            grant = GNT_DBG;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and debug accesses onto one memory port with a one-cycle ack per transaction.
// Contention policy selected by MEM_ARB_FIXED_PRIO_EN (see arb_pick).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LATENCY - 1);

    arb_state_t           state;
    grant_t               gnt;
    grant_t               last_grant;
    grant_t               pick_gnt;
    logic                 any_req;
    logic                 lat_we;
    logic [LAT_CNT_W-1:0] lat_cnt;

    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;

    arb_pick u_pick (
        .cpu_req    (cpu_req),
        .dbg_req    (dbg_req),
        .last_grant (last_grant),
        .any_req    (any_req),
        .grant      (pick_gnt)
    );

    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (pick_gnt == GNT_DBG) begin
            sel_we    = dbg_we;
            sel_addr  = dbg_addr;
            sel_wdata = dbg_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= GNT_CPU;
            last_grant <= GNT_DBG;
            lat_we     <= 1'b0;
            lat_cnt    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_ack    <= 1'b0;
            dbg_ack    <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt       <= pick_gnt;
                        lat_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_en    <= 1'b1;
                        mem_we    <= sel_we;
                        state     <= ISSUE;
                    end
                end
                // WAIT always spans MEM_LATENCY cycles so data is captured at the end of
                // cycle 1+MEM_LATENCY and the ack lands in cycle 2+MEM_LATENCY.
                ISSUE: begin
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    lat_cnt <= LAT_INIT;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        if (gnt == GNT_CPU) begin
                            cpu_ack <= 1'b1;
                            if (!lat_we) cpu_rdata <= mem_rdata;
                        end else begin
                            dbg_ack <= 1'b1;
                            if (!lat_we) dbg_rdata <= mem_rdata;
                        end
                        state <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                DONE: begin
                    cpu_ack    <= 1'b0;
                    dbg_ack    <= 1'b0;
                    last_grant <= gnt;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter at MEM_LATENCY 1, 3 and 4, each with its own memory
// and transaction-timeline model; honours MEM_ARB_FIXED_PRIO_EN for contention expectations.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string name, input int unsigned lat, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (MEM_LATENCY=%0d): got %h, expected %h", name, lat, act, exp);
        end
    endtask

    // Returns 1 when the debug port should be served.
    function automatic bit pick(input bit c, input bit d, input bit last_dbg);
        if (c && d) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            return 1'b0;
`else
            return !last_dbg;
`endif
        end
        return d;
    endfunction

    function automatic logic [31:0] preload(input int i);
        if (i == 16) return 32'hDEADBEEF;
        return {16'h5A5A, 16'(i)};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 3 : 4;

        logic        reset     = 1'b1;
        logic        cpu_req   = 1'b0;
        logic        cpu_we    = 1'b0;
        logic [31:0] cpu_addr  = '0;
        logic [31:0] cpu_wdata = '0;
        logic        dbg_req   = 1'b0;
        logic        dbg_we    = 1'b0;
        logic [31:0] dbg_addr  = '0;
        logic [31:0] dbg_wdata = '0;
        logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
        logic        cpu_ack, dbg_ack, mem_en, mem_we;
        bit          done = 1'b0;
        int unsigned en_cnt = 0;
        int unsigned dbg_ack_cnt = 0;

        mem_arbiter #(
            .ADDR_W      (32),
            .DATA_W      (32),
            .MEM_LATENCY (L)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .cpu_req   (cpu_req),
            .cpu_we    (cpu_we),
            .cpu_addr  (cpu_addr),
            .cpu_wdata (cpu_wdata),
            .cpu_rdata (cpu_rdata),
            .cpu_ack   (cpu_ack),
            .dbg_req   (dbg_req),
            .dbg_we    (dbg_we),
            .dbg_addr  (dbg_addr),
            .dbg_wdata (dbg_wdata),
            .dbg_rdata (dbg_rdata),
            .dbg_ack   (dbg_ack),
            .mem_en    (mem_en),
            .mem_we    (mem_we),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_rdata (mem_rdata)
        );

        // Memory: read data valid only in cycle issue+L, garbage otherwise.
        logic [31:0] mem [256];
        bit          mem_loaded = 1'b0;
        int          rd_cnt = 0;
        logic [31:0] rd_data = '0;
        assign mem_rdata = (rd_cnt == 1) ? rd_data : 32'hBAD0_0BAD;

        always @(posedge clk) begin
            if (!mem_loaded) begin
                for (int i = 0; i < 256; i++) mem[i] <= preload(i);
                mem_loaded <= 1'b1;
            end
            if (reset) begin
                rd_cnt <= 0;
            end else if (mem_en) begin
                if (mem_we) begin
                    mem[mem_addr[9:2]] <= mem_wdata;
                end else begin
                    rd_data <= mem[mem_addr[9:2]];
                    rd_cnt  <= int'(L);
                end
            end else if (rd_cnt > 0) begin
                rd_cnt <= rd_cnt - 1;
            end
        end

        always @(posedge clk) begin
            if (mem_en) en_cnt <= en_cnt + 1;
            if (dbg_ack) dbg_ack_cnt <= dbg_ack_cnt + 1;
        end

        // Model: a transaction accepted at step 0 occupies steps 1..L+2; step 1 strobes
        // memory, step L+2 carries the ack and fresh read data.
        logic [31:0] ref_mem [256];
        bit          m_valid = 1'b0;
        int unsigned step = 0;
        bit          x_last, x_gnt, x_we;
        logic [31:0] x_rval;
        logic        x_mem_en, x_mem_we, x_cpu_ack, x_dbg_ack;
        logic [31:0] x_addr, x_wdata, x_cpu_rdata, x_dbg_rdata;
        logic        m_pick, m_we;
        logic [31:0] m_addr, m_wdata;
        assign m_pick  = pick(cpu_req, dbg_req, x_last);
        assign m_we    = m_pick ? dbg_we : cpu_we;
        assign m_addr  = m_pick ? dbg_addr : cpu_addr;
        assign m_wdata = m_pick ? dbg_wdata : cpu_wdata;

        always @(posedge clk) begin
            if (!m_valid) begin
                for (int i = 0; i < 256; i++) ref_mem[i] <= preload(i);
            end
            if (reset) begin
                m_valid     <= 1'b1;
                step        <= 0;
                x_last      <= 1'b1;
                x_mem_en    <= 1'b0;
                x_mem_we    <= 1'b0;
                x_addr      <= '0;
                x_wdata     <= '0;
                x_cpu_ack   <= 1'b0;
                x_dbg_ack   <= 1'b0;
                x_cpu_rdata <= '0;
                x_dbg_rdata <= '0;
            end else begin
                x_mem_en  <= 1'b0;
                x_mem_we  <= 1'b0;
                x_cpu_ack <= 1'b0;
                x_dbg_ack <= 1'b0;
                if (step == 0) begin
                    if (cpu_req || dbg_req) begin
                        x_gnt    <= m_pick;
                        x_we     <= m_we;
                        x_mem_en <= 1'b1;
                        x_mem_we <= m_we;
                        x_addr   <= m_addr;
                        x_wdata  <= m_wdata;
                        if (m_we) ref_mem[m_addr[9:2]] <= m_wdata;
                        else x_rval <= ref_mem[m_addr[9:2]];
                        step <= 1;
                    end
                end else if (step == L + 1) begin
                    if (x_gnt) x_dbg_ack <= 1'b1;
                    else x_cpu_ack <= 1'b1;
                    if (!x_we) begin
                        if (x_gnt) x_dbg_rdata <= x_rval;
                        else x_cpu_rdata <= x_rval;
                    end
                    step <= step + 1;
                end else if (step == L + 2) begin
                    step   <= 0;
                    x_last <= x_gnt;
                end else begin
                    step <= step + 1;
                end
            end
        end

        always @(negedge clk) begin
            if (m_valid) begin
                chk("mem_en", L, 32'(mem_en), 32'(x_mem_en));
                chk("mem_we", L, 32'(mem_we), 32'(x_mem_we));
                chk("mem_addr", L, mem_addr, x_addr);
                chk("mem_wdata", L, mem_wdata, x_wdata);
                chk("cpu_ack", L, 32'(cpu_ack), 32'(x_cpu_ack));
                chk("dbg_ack", L, 32'(dbg_ack), 32'(x_dbg_ack));
                chk("cpu_rdata", L, cpu_rdata, x_cpu_rdata);
                chk("dbg_rdata", L, dbg_rdata, x_dbg_rdata);
            end
        end

        task automatic wait_ack(input bit on_dbg, output int unsigned n);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(on_dbg ? dbg_ack : cpu_ack) && n < 64);
            chk("ack_seen", L, 32'(on_dbg ? dbg_ack : cpu_ack), 32'd1);
        endtask

        task automatic wait_any(output int unsigned n, output bit who);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(cpu_ack || dbg_ack) && n < 64);
            who = dbg_ack;
            chk("any_ack_seen", L, 32'(cpu_ack | dbg_ack), 32'd1);
        endtask

        task automatic txn(input bit on_dbg, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int unsigned n);
            if (on_dbg) begin
                dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
            end else begin
                cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
            end
            wait_ack(on_dbg, n);
            cpu_req = 1'b0;
            dbg_req = 1'b0;
            @(negedge clk);
        endtask

        initial begin : stim
            int unsigned n, t, t_prev, e0, d0;
            bit          who;
            logic [3:0]  exp_order;
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_order = 4'b0000;
`else
            exp_order = 4'b1010;
`endif
            repeat (2) @(negedge clk);
            chk("rst_mem_en", L, 32'(mem_en), 32'd0);
            chk("rst_cpu_ack", L, 32'(cpu_ack), 32'd0);
            chk("rst_mem_addr", L, mem_addr, 32'd0);
            chk("rst_cpu_rdata", L, cpu_rdata, 32'd0);
            reset = 1'b0;
            @(negedge clk);

            // Single CPU read of preloaded word.
            d0 = dbg_ack_cnt;
            e0 = en_cnt;
            txn(1'b0, 1'b0, 32'h40, 32'h0, n);
            chk("t1_ack_cycle", L, n, L + 2);
            chk("t1_cpu_rdata", L, cpu_rdata, 32'hDEADBEEF);
            chk("t1_mem_en_pulses", L, en_cnt - e0, 32'd1);
            chk("t1_no_dbg_ack", L, dbg_ack_cnt - d0, 32'd0);

            // Debug write, then CPU reads it back.
            txn(1'b1, 1'b1, 32'h80, 32'h12345678, n);
            chk("t2_dbg_ack_cycle", L, n, L + 2);
            chk("t2_dbg_rdata_kept", L, dbg_rdata, 32'd0);
            txn(1'b0, 1'b0, 32'h80, 32'h0, n);
            chk("t2_cpu_rdata", L, cpu_rdata, 32'h12345678);

            // Contention straight after reset, both requests held.
            reset = 1'b1;
            @(negedge clk);
            reset   = 1'b0;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
            dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h80;
            t = 0;
            for (int i = 0; i < 4; i++) begin
                wait_any(n, who);
                t += n;
                chk("t3_grant_order", L, 32'(who), 32'(exp_order[i]));
                if (i == 0) chk("t3_first_ack_cycle", L, t, L + 2);
                if (i == 1) chk("t3_second_ack_cycle", L, t, 2 * L + 5);
                if (who) chk("t3_dbg_rdata", L, dbg_rdata, 32'h12345678);
                else chk("t3_cpu_rdata", L, cpu_rdata, 32'hDEADBEEF);
            end
            cpu_req = 1'b0;
            dbg_req = 1'b0;
            @(negedge clk);

            // CPU request held across three back-to-back writes.
            e0 = en_cnt;
            t = 0;
            t_prev = 0;
            cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hC0DE0000; cpu_req = 1'b1;
            for (int i = 0; i < 3; i++) begin
                wait_ack(1'b0, n);
                t += n;
                if (i > 0) chk("t4_ack_spacing", L, t - t_prev, L + 3);
                t_prev = t;
                cpu_addr  = cpu_addr + 32'd4;
                cpu_wdata = cpu_wdata + 32'd1;
            end
            cpu_req = 1'b0;
            cpu_we  = 1'b0;
            @(negedge clk);
            chk("t4_mem_en_pulses", L, en_cnt - e0, 32'd3);
            txn(1'b0, 1'b0, 32'h108, 32'h0, n);
            chk("t4_readback", L, cpu_rdata, 32'hC0DE0002);

            // Reset in cycle 3 of a CPU read abandons it.
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
            repeat (3) @(negedge clk);
            reset   = 1'b1;
            cpu_req = 1'b0;
            @(negedge clk);
            chk("t5_mem_en", L, 32'(mem_en), 32'd0);
            chk("t5_mem_we", L, 32'(mem_we), 32'd0);
            chk("t5_cpu_ack", L, 32'(cpu_ack), 32'd0);
            chk("t5_cpu_rdata", L, cpu_rdata, 32'd0);
            reset   = 1'b0;
            cpu_req = 1'b1;
            dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h80;
            wait_any(n, who);
            chk("t5_winner_is_cpu", L, 32'(who), 32'd0);
            chk("t5_ack_cycle", L, n, L + 2);
            cpu_req = 1'b0;
            dbg_req = 1'b0;
            @(negedge clk);
            done = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            if (g_inst[0].done && g_inst[1].done && g_inst[2].done) break;
        end
        chk("all_done", 0,
            32'(g_inst[0].done && g_inst[1].done && g_inst[2].done), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
